// File: rtl/fft_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Purpose  : Ping-pong reorder of FFT32 bit-reversed output into natural order.
// Revision : 1.0
// ============================================================================
module fft_bitrev_reorder #(
    parameter int NB   = 16,
    parameter int LOGN = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [NB-1:0]   DR,
    input  logic [NB-1:0]   DI,
    output logic [NB-1:0]   OR,
    output logic [NB-1:0]   OI,
    output logic            OVALID,
    output logic            OSTART,
    output logic [LOGN-1:0] OIDX
);

    localparam int              c_n    = 2 ** LOGN;
    localparam logic [LOGN-1:0] c_last = '1;

    typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_OUT  = 1'b1} rd_state_t;

    wr_state_t        r_wr_state, w_wr_state_nxt;
    logic [LOGN-1:0]  r_wr_cnt,   w_wr_cnt_nxt;
    logic             r_wbank,    w_wbank_nxt;
    logic             w_wr_en;
    logic [LOGN-1:0]  w_wr_addr;
    logic             w_commit;

    rd_state_t        r_rd_state, w_rd_state_nxt;
    logic [LOGN-1:0]  r_rd_cnt,   w_rd_cnt_nxt;
    logic             r_rbank,    w_rbank_nxt;
    logic [2*NB-1:0]  w_rd_word;

    logic [2*NB-1:0]  r_mem [0:1][0:c_n-1];

    function automatic logic [LOGN-1:0] f_bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] v;
        for (int i = 0; i < LOGN; i++) begin
            v[i] = a[LOGN-1-i];
        end
        return v;
    endfunction

    // START always restarts at index 0 of the current bank; a partial frame is simply overwritten
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_wbank_nxt    = r_wbank;
        w_wr_en        = 1'b0;
        w_wr_addr      = f_bitrev(r_wr_cnt);
        w_commit       = 1'b0;
        if (START) begin
            w_wr_en        = 1'b1;
            w_wr_addr      = '0;
            w_wr_cnt_nxt   = LOGN'(1);
            w_wr_state_nxt = W_FILL;
        end else if (r_wr_state == W_FILL) begin
            w_wr_en = 1'b1;
            if (r_wr_cnt == c_last) begin
                w_commit       = 1'b1;
                w_wbank_nxt    = ~r_wbank;
                w_wr_cnt_nxt   = '0;
                w_wr_state_nxt = W_IDLE;
            end else begin
                w_wr_cnt_nxt = r_wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= '0;
            r_wbank    <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_wbank    <= w_wbank_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wbank][w_wr_addr] <= {DR, DI};
        end
    end

    // A commit landing on the last read address restarts the sweep without a bubble
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_rbank_nxt    = r_rbank;
        if (r_rd_state == R_OUT) begin
            if (r_rd_cnt == c_last) begin
                w_rd_state_nxt = R_IDLE;
                w_rd_cnt_nxt   = '0;
            end else begin
                w_rd_cnt_nxt = r_rd_cnt + 1'b1;
            end
        end
        if (w_commit) begin
            w_rd_state_nxt = R_OUT;
            w_rd_cnt_nxt   = '0;
            w_rbank_nxt    = r_wbank;
        end
    end

    assign w_rd_word = r_mem[r_rbank][r_rd_cnt];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= '0;
            r_rbank    <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_rbank    <= w_rbank_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OR     <= '0;
            OI     <= '0;
            OIDX   <= '0;
            OVALID <= 1'b0;
            OSTART <= 1'b0;
        end else if (r_rd_state == R_OUT) begin
            OR     <= w_rd_word[2*NB-1:NB];
            OI     <= w_rd_word[NB-1:0];
            OIDX   <= r_rd_cnt;
            OVALID <= 1'b1;
            OSTART <= (r_rd_cnt == '0);
        end else begin
            OVALID <= 1'b0;
            OSTART <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_reorder
// Purpose  : Scoreboard bench for fft_bitrev_reorder against a reorder model.
// Revision : 1.0
// ============================================================================
module tb_fft_bitrev_reorder;

    localparam int NB   = 16;
    localparam int LOGN = 5;
    localparam int N    = 2 ** LOGN;

    logic            CLK;
    logic            RST;
    logic            START;
    logic [NB-1:0]   DR;
    logic [NB-1:0]   DI;
    logic [NB-1:0]   OR;
    logic [NB-1:0]   OI;
    logic            OVALID;
    logic            OSTART;
    logic [LOGN-1:0] OIDX;

    fft_bitrev_reorder #(.NB(NB), .LOGN(LOGN)) dut (
        .CLK(CLK), .RST(RST), .START(START), .DR(DR), .DI(DI),
        .OR(OR), .OI(OI), .OVALID(OVALID), .OSTART(OSTART), .OIDX(OIDX)
    );

    typedef struct {
        logic [NB-1:0]   r;
        logic [NB-1:0]   i;
        logic [LOGN-1:0] idx;
        logic            st;
        int              cyc;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            total = 0;
    int            passed = 0;

    logic [NB-1:0] buf_r [N];
    logic [NB-1:0] buf_i [N];
    int            k_in = 0;
    int            fstart = 0;
    bit            in_frame = 0;

    logic [NB-1:0]   last_r = '0;
    logic [NB-1:0]   last_i = '0;
    logic [LOGN-1:0] last_idx = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int rev(input int v);
        int r = 0;
        for (int b = 0; b < LOGN; b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Model: a completed frame's natural bin j is the input sample taken at position bitrev(j)
    task automatic drive(input bit st, input logic [NB-1:0] r, input logic [NB-1:0] i);
        exp_t e;
        START = st; DR = r; DI = i;
        if (st) begin
            k_in = 0; fstart = cyc; in_frame = 1;
        end
        if (in_frame) begin
            buf_r[k_in] = r; buf_i[k_in] = i; k_in++;
            if (k_in == N) begin
                in_frame = 0;
                for (int j = 0; j < N; j++) begin
                    e.r = buf_r[rev(j)]; e.i = buf_i[rev(j)];
                    e.idx = LOGN'(j); e.st = (j == 0); e.cyc = fstart + N + 1 + j;
                    sb.push_back(e);
                end
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, NB'($urandom()), NB'($urandom()));
    endtask

    task automatic send_frame(input bit rnd, input int off);
        logic [NB-1:0] d;
        for (int k = 0; k < N; k++) begin
            d = NB'(off + rev(k));
            if (rnd) drive(k == 0, NB'($urandom()), NB'($urandom()));
            else     drive(k == 0, d, d);
        end
    endtask

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) drive(k == 0, NB'($urandom()), NB'($urandom()));
    endtask

    task automatic do_reset();
        RST = 1'b0; START = 1'b0;
        sb.delete(); in_frame = 0;
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            chk({OVALID, OSTART, OIDX, OR, OI} == '0, "reset_outputs",
                64'({OVALID, OSTART, OIDX, OR, OI}), 64'(0));
            last_r = '0; last_i = '0; last_idx = '0;
        end else if (OVALID) begin
            chk(sb.size() != 0, "unexpected_valid", 64'(OIDX), 64'(0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({OR, OI} == {e.r, e.i}, "data", 64'({OR, OI}), 64'({e.r, e.i}));
                chk(OIDX == e.idx, "oidx", 64'(OIDX), 64'(e.idx));
                chk(OSTART == e.st, "ostart", 64'(OSTART), 64'(e.st));
                chk(cyc == e.cyc, "timing", 64'(cyc), 64'(e.cyc));
            end
            last_r = OR; last_i = OI; last_idx = OIDX;
        end else begin
            chk(OSTART == 1'b0, "ostart_idle", 64'(OSTART), 64'(0));
            chk({OR, OI, OIDX} == {last_r, last_i, last_idx}, "hold",
                64'({OR, OI, OIDX}), 64'({last_r, last_i, last_idx}));
            if (sb.size() != 0) begin
                chk(sb[0].cyc > cyc, "missing_output", 64'(cyc), 64'(sb[0].cyc));
                if (sb[0].cyc <= cyc) void'(sb.pop_front());
            end
        end
    end

    initial begin
        RST = 1'b0; START = 1'b0; DR = '0; DI = '0;
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b1;

        send_frame(1'b0, 0);
        idle(5);
        for (int f = 0; f < 3; f++) send_frame(1'b0, f * 256);
        idle(40);

        send_frame(1'b1, 0);
        idle(7);
        send_frame(1'b1, 0);
        idle(40);

        send_partial(10);
        send_frame(1'b0, 'h300);
        idle(40);

        send_frame(1'b1, 0);
        idle(13);
        do_reset();
        send_frame(1'b0, 'h400);
        idle(40);

        for (int f = 0; f < 20; f++) begin
            send_frame(1'b1, 0);
            idle($urandom_range(0, 3));
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        chk(sb.size() == 0, "drain", 64'(sb.size()), 64'(0));
        idle(5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter NB, default 16, the sample word width (SFP format), equal to the FFT32 nb.
REQ-002 SHALL have parameter LOGN, default 5, log2 of the frame length; the frame length is N = 2^LOGN = 32.
REQ-003 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  one-cycle pulse marking input sample 0 of a frame; it coincides with that sample on DR/DI.
REQ-006 DR  input  NB  real part of the FFT32 output sample, in bit-reversed order.
REQ-007 DI  input  NB  imaginary part of the FFT32 output sample, in bit-reversed order.
REQ-008 OR  output  NB  real part of the output sample, in natural order, registered.
REQ-009 OI  output  NB  imaginary part of the output sample, in natural order, registered.
REQ-010 OVALID  output  1  high while OR/OI carry a valid sample.
REQ-011 OSTART  output  1  high with output bin 0 of each frame only.
REQ-012 OIDX  output  LOGN  natural bin index of the current OR/OI sample.

Function
REQ-013 SHALL treat data as opaque NB-bit words; no arithmetic SHALL be applied to the samples.
REQ-014 SHALL contain two N-entry banks (ping-pong); each entry holds {DR,DI}.
REQ-015 Write FSM states SHALL be W_IDLE and W_FILL.
- W_IDLE to W_FILL on START.
- W_FILL to W_IDLE after sample N-1, unless START is present.
REQ-016 Write addressing SHALL be as follows.
- Input sample k of a frame (k=0 is the START cycle, k=1..N-1 the following N-1 consecutive cycles) SHALL be written to wbank[bitrev_LOGN(k)].
- Input is contiguous; there is no input valid.
REQ-017 When sample N-1 is written, the frame SHALL be committed.
- wbank toggles.
- A read of the committed bank is requested for the next cycle.
REQ-018 START in the same cycle as sample N-1 of the previous frame is impossible. START at k=N (the cycle after sample N-1) SHALL begin the next frame in the toggled bank, back-to-back.
REQ-019 START while in W_FILL with k<N-1 SHALL abort the partial frame.
- The abort is silent: no commit, no output.
- Writing restarts at k=0 in the same bank, with the START sample written to index 0.
REQ-020 Read FSM states SHALL be R_IDLE and R_OUT.
- On a commit, R_OUT reads the committed bank at addresses 0..N-1 on consecutive cycles.
- It returns to R_IDLE after address N-1, or restarts at 0 if a new commit arrives in that same cycle.
REQ-021 Latency: for START in cycle t, bin 0 SHALL appear on OR/OI with OVALID=1 and OSTART=1 in cycle t+N+1 (t+33).
- Bins 1..N-1 follow on cycles t+34..t+64.
- OIDX equals the bin number on each of those cycles.
REQ-022 For back-to-back frames, OVALID SHALL stay continuously high; OSTART pulses every N cycles.
REQ-023 When not outputting, OVALID=0 and OSTART=0. OR/OI/OIDX SHALL hold their last value.
REQ-024 Writes never collide with the bank being read; this is guaranteed by REQ-017/018, since reading N entries takes exactly N cycles.

Reset
REQ-025 While RST=0, all of the following SHALL hold asynchronously.
- OR=0, OI=0, OIDX=0, OVALID=0, OSTART=0.
- Both FSMs are idle, write/read counters are 0, and wbank=0.
REQ-026 Bank memory contents SHALL NOT require reset.
REQ-027 Reset asserted mid-frame or mid-readout SHALL discard all pending data. After release, no output appears until a full new frame is written.
REQ-028 START is honoured on the first rising edge after RST deasserts.

Verification
REQ-029 Single frame: START at cycle t, input word k = bitrev5(j) for j in order (DR=DI=value) -> OR=OI=0,1,...,31 on cycles t+33..t+64, OSTART only at t+33, OIDX=0..31.
REQ-030 Three back-to-back frames with offsets 0x000/0x100/0x200 -> 96 contiguous OVALID cycles and natural ramps per frame; OSTART at t+33, t+65, t+97.
REQ-031 Abort: START, 10 samples, START again, 32 samples -> exactly one 32-sample output frame, containing only the second frame's data; bin 0 appears 33 cycles after the second START.
REQ-032 Gap: frame, 7 idle cycles, frame -> OVALID low for exactly 7 cycles between the frames; OR/OI held during the gap.
REQ-033 Reset mid-readout: RST low at output bin 12, released, then a new frame -> outputs 0 with OVALID=0 immediately; the next output is the new frame's bin 0 at START+33.
REQ-034 Random NB-bit data over 20 frames, checked against a software bit-reverse model -> exact match on every sample and every OIDX.
